// File: rtl/history_serializer.sv
// Snapshots a parallel history (data + valid vector) on snap_req and streams the
// valid entries out newest-first over a registered valid/ready interface.
module history_serializer #(
    parameter  int DATA_W    = 8,
    parameter  int HISTORY_L = 4,
    localparam int IDX_W     = $clog2(HISTORY_L)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [DATA_W-1:0]    hist_data_in [HISTORY_L],
    input  logic [HISTORY_L-1:0] hist_valid_in,
    input  logic                 snap_req,
    output logic                 snap_busy,
    output logic                 snap_empty,
    output logic [IDX_W:0]       snap_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [IDX_W-1:0]     out_index,
    output logic                 out_last
);

    typedef enum logic [0:0] {IDLE, STREAM} state_e;

    state_e                 state_q, state_d;
    logic [HISTORY_L-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]      shadow_q [HISTORY_L];
    logic [DATA_W-1:0]      shadow_d [HISTORY_L];
    logic [IDX_W:0]         snap_count_q, snap_count_d;
    logic                   snap_empty_q, snap_empty_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [IDX_W-1:0]       out_index_q, out_index_d;
    logic                   out_last_q, out_last_d;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [HISTORY_L-1:0] m);
        lowest_idx = '0;
        for (int i = HISTORY_L - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [HISTORY_L-1:0] m);
        popcount = '0;
        for (int i = 0; i < HISTORY_L; i++) begin
            popcount = popcount + {{IDX_W{1'b0}}, m[i]};
        end
    endfunction

    // Output fields are precomputed from the next-cycle mask so the presented
    // entry comes straight from flops and never depends on out_ready.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        state_d      = state_q;
        mask_d       = mask_q;
        shadow_d     = shadow_q;
        snap_count_d = snap_count_q;
        snap_empty_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    shadow_d     = hist_data_in;
                    mask_d       = hist_valid_in;
                    snap_count_d = popcount(hist_valid_in);
                    if (hist_valid_in != '0) state_d = STREAM;
                    else                     snap_empty_d = 1'b1;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    mask_d[out_index_q] = 1'b0;
                    if (out_last_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_index_d = lowest_idx(mask_d);
        out_data_d  = shadow_d[out_index_d];
        out_last_d  = (popcount(mask_d) == (IDX_W + 1)'(1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            snap_count_q <= '0;
            snap_empty_q <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            // NOTE: the shadow store is small and its contents are observable
            // after reset, so it is cleared explicitly rather than left unreset.
            for (int i = 0; i < HISTORY_L; i++) shadow_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            mask_q       <= mask_d;
            shadow_q     <= shadow_d;
            snap_count_q <= snap_count_d;
            snap_empty_q <= snap_empty_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = (state_q == STREAM);
    assign snap_busy  = (state_q == STREAM);
    assign snap_empty = snap_empty_q;
    assign snap_count = snap_count_q;
    assign out_data   = out_data_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_history_serializer.sv
// Directed self-checking bench for history_serializer: inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
module tb_history_serializer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] hist_data_in [4];
    logic [3:0] hist_valid_in;
    logic       snap_req;
    logic       snap_busy;
    logic       snap_empty;
    logic [2:0] snap_count;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_index;
    logic       out_last;

    int n_pass  = 0;
    int n_total = 0;

    history_serializer #(.DATA_W(8), .HISTORY_L(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .hist_data_in  (hist_data_in),
        .hist_valid_in (hist_valid_in),
        .snap_req      (snap_req),
        .snap_busy     (snap_busy),
        .snap_empty    (snap_empty),
        .snap_count    (snap_count),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_last      (out_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic expect_entry(input string tag, input logic [7:0] d,
                                input logic [1:0] idx, input logic last);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_index"}, 32'(out_index), 32'(idx));
        check({tag, "_last"},  32'(out_last),  32'(last));
        check({tag, "_busy"},  32'(snap_busy), 32'd1);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},  32'(snap_busy), 32'd0);
    endtask

    task automatic set_hist(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3,
                            input logic [3:0] v);
        hist_data_in[0] = d0;
        hist_data_in[1] = d1;
        hist_data_in[2] = d2;
        hist_data_in[3] = d3;
        hist_valid_in   = v;
    endtask

    // Raise snap_req for one capture edge; returns at the falling edge of cycle N+1.
    task automatic pulse_snap();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_seq [3];
        int         k;
        int         guard;

        reset_n   = 1'b1;
        snap_req  = 1'b0;
        out_ready = 1'b0;
        set_hist(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        #1 reset_n = 1'b0;
        #1;
        expect_idle("rst");
        check("rst_empty", 32'(snap_empty), 32'd0);
        check("rst_count", 32'(snap_count), 32'd0);
        check("rst_data",  32'(out_data),   32'd0);
        check("rst_last",  32'(out_last),   32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        expect_idle("post_rst");

        // 1: thermometer vector, ready held high
        set_hist(8'h11, 8'h22, 8'h33, 8'h44, 4'b0111);
        out_ready = 1'b1;
        pulse_snap();
        expect_entry("t1_e0", 8'h11, 2'd0, 1'b0);
        check("t1_count", 32'(snap_count), 32'd3);
        step();
        expect_entry("t1_e1", 8'h22, 2'd1, 1'b0);
        step();
        expect_entry("t1_e2", 8'h33, 2'd2, 1'b1);
        step();
        expect_idle("t1_end");
        check("t1_count_hold", 32'(snap_count), 32'd3);

        // 2: same snapshot, ready toggling 1,0,1,0,...
        exp_seq = '{8'h11, 8'h22, 8'h33};
        pulse_snap();
        k = 0;
        guard = 0;
        while (k < 3 && guard < 10) begin
            expect_entry($sformatf("t2_c%0d", guard), exp_seq[k], 2'(k), k == 2);
            out_ready = (guard % 2 == 0);
            step();
            if (out_ready) k++;
            guard++;
        end
        check("t2_transfers", 32'(k), 32'd3);
        check("t2_cycles", 32'(guard), 32'd5);
        expect_idle("t2_end");
        out_ready = 1'b1;

        // 3: empty snapshot
        set_hist(8'h55, 8'h66, 8'h77, 8'h88, 4'b0000);
        pulse_snap();
        check("t3_empty_pulse", 32'(snap_empty), 32'd1);
        check("t3_count", 32'(snap_count), 32'd0);
        expect_idle("t3_n1");
        step();
        check("t3_empty_drop", 32'(snap_empty), 32'd0);
        expect_idle("t3_n2");

        // 4: sparse vector; history inputs scribbled mid-stream
        set_hist(8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b1010);
        pulse_snap();
        set_hist(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b1111);
        expect_entry("t4_e0", 8'hB1, 2'd1, 1'b0);
        check("t4_count", 32'(snap_count), 32'd2);
        step();
        expect_entry("t4_e1", 8'hD3, 2'd3, 1'b1);
        step();
        expect_idle("t4_end");

        // 5: full vector, snap_req held high across the return to IDLE
        set_hist(8'h01, 8'h02, 8'h03, 8'h04, 4'b1111);
        snap_req = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            expect_entry($sformatf("t5a_e%0d", i), 8'(i + 1), 2'(i), i == 3);
            step();
        end
        expect_idle("t5_gap");
        check("t5_count", 32'(snap_count), 32'd4);
        set_hist(8'h10, 8'h20, 8'h30, 8'h40, 4'b1111);
        step();
        snap_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_entry($sformatf("t5b_e%0d", i), 8'((i + 1) * 16), 2'(i), i == 3);
            step();
        end
        expect_idle("t5_end");

        // 6: asynchronous reset mid-stream, then a fresh snapshot
        set_hist(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
        out_ready = 1'b0;
        pulse_snap();
        expect_entry("t6_pre", 8'h11, 2'd0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        expect_idle("t6_rst");
        check("t6_rst_count", 32'(snap_count), 32'd0);
        check("t6_rst_data",  32'(out_data),   32'd0);
        step();
        #2 reset_n = 1'b1;
        step();
        expect_idle("t6_release");
        set_hist(8'h5A, 8'hA5, 8'h00, 8'h00, 4'b0011);
        out_ready = 1'b1;
        pulse_snap();
        expect_entry("t6_e0", 8'h5A, 2'd0, 1'b0);
        check("t6_count", 32'(snap_count), 32'd2);
        step();
        expect_entry("t6_e1", 8'hA5, 2'd1, 1'b1);
        step();
        expect_idle("t6_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
